cmd_frame_initiator: RTL and testbench

- Host-side command initiator: the other end of the system controller's UART command protocol.
- Accepts one command request per handshake and serialises it into protocol bytes on a byte-wide TX interface.
- Collects the response bytes from a byte-wide RX interface and presents the assembled result.
- Drives the UART link used by the system top. Serves as the bring-up and loopback source for the on-chip controller.

---
 rtl/sys_cmd_pkg.sv | 23 ++
 rtl/cmd_frame_initiator.sv | 130 +++++++++++++
 tb/tb_cmd_frame_initiator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: shared frame headers, command encodings, FSM states and frame length for the UART command protocol
package sys_cmd_pkg;
    localparam logic [7:0] RF_WR_CMD   = 8'hAA;
    localparam logic [7:0] RF_RD_CMD   = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;
    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'b00,
        CMD_RF_RD   = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_R0,
        S_WAIT_R1,
        S_DONE
    } state_e;
    function automatic logic [2:0] frame_len(input cmd_type_e t);
        return t == CMD_RF_WR ? 3'd3 : t == CMD_ALU_OP ? 3'd4 : 3'd2;
    endfunction
endpackage

// File: rtl/cmd_frame_initiator.sv
// cmd_frame_initiator: serialises one command into protocol bytes on TX and assembles the RX response
// Ports: CLK/RST (sync, active-high); CMD_* request with valid/ready handshake;
//        TX_P_DATA/TX_DATA_VALID/TX_FULL byte sink; RX_P_DATA/RX_DATA_VALID byte source;
//        RESP_DATA assembled response, CMD_DONE completion pulse, RESP_ERR timeout pulse.
// Optional macro CMD_RESP_TIMEOUT_EN adds a response watchdog; otherwise RESP_ERR is tied 0.
module cmd_frame_initiator
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int OUT_WIDTH      = 2*DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_TYPE,
    input  logic [ADDRESS_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]    CMD_WDATA,
    input  logic [DATA_WIDTH-1:0]    CMD_OP_A,
    input  logic [DATA_WIDTH-1:0]    CMD_OP_B,
    input  logic [FUN_WIDTH-1:0]     CMD_FUN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_DATA_VALID,
    input  logic                     TX_FULL,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_DATA_VALID,
    output logic [OUT_WIDTH-1:0]     RESP_DATA,
    output logic                     CMD_DONE,
    output logic                     RESP_ERR
);
    state_e                   r_state, w_next;
    cmd_type_e                r_type;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_op_a, r_op_b;
    logic [FUN_WIDTH-1:0]     r_fun;
    logic [1:0]               r_idx;
    logic [OUT_WIDTH-1:0]     r_resp;
    logic [DATA_WIDTH-1:0]    w_byte, w_addr_b, w_fun_b;
    logic                     w_xfer, w_last, w_timeout;
    assign w_xfer        = r_state == S_SEND && !TX_FULL;
    assign w_last        = {1'b0, r_idx} == frame_len(r_type) - 3'd1;
    assign w_addr_b      = DATA_WIDTH'(r_addr);
    assign w_fun_b       = DATA_WIDTH'(r_fun);
    assign CMD_READY     = r_state == S_IDLE;
    assign TX_DATA_VALID = r_state == S_SEND;
    assign TX_P_DATA     = r_state == S_SEND ? w_byte : '0;
    assign CMD_DONE      = r_state == S_DONE;
    assign RESP_DATA     = r_resp;
    always_comb begin
        w_byte = '0;
        case (r_type)
            CMD_RF_WR:  w_byte = r_idx == 2'd0 ? DATA_WIDTH'(RF_WR_CMD) : r_idx == 2'd1 ? w_addr_b : r_wdata;
            CMD_RF_RD:  w_byte = r_idx == 2'd0 ? DATA_WIDTH'(RF_RD_CMD) : w_addr_b;
            CMD_ALU_OP: w_byte = r_idx == 2'd0 ? DATA_WIDTH'(ALU_OP_CMD) : r_idx == 2'd1 ? r_op_a :
                                 r_idx == 2'd2 ? r_op_b : w_fun_b;
            default:    w_byte = r_idx == 2'd0 ? DATA_WIDTH'(ALU_NOP_CMD) : w_fun_b;
        endcase
    end
    // RX bytes are only looked at in the WAIT states, so anything arriving
    // during SEND (including on the last transfer cycle) is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = CMD_VALID ? S_SEND : S_IDLE;
            S_SEND:    if (w_xfer && w_last) w_next = r_type == CMD_RF_WR ? S_DONE : S_WAIT_R0;
            S_WAIT_R0: if (RX_DATA_VALID) w_next = r_type == CMD_RF_RD ? S_DONE : S_WAIT_R1;
                       else if (w_timeout) w_next = S_DONE;
            S_WAIT_R1: if (RX_DATA_VALID || w_timeout) w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_type  <= CMD_RF_WR;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_fun   <= '0;
            r_idx   <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && CMD_VALID) begin
                r_type  <= cmd_type_e'(CMD_TYPE);
                r_addr  <= CMD_ADDR;
                r_wdata <= CMD_WDATA;
                r_op_a  <= CMD_OP_A;
                r_op_b  <= CMD_OP_B;
                r_fun   <= CMD_FUN;
                r_idx   <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            // Read responses are a single byte, so the upper half is cleared;
            // ALU responses arrive LSB first and keep the upper half until byte 1.
            if (r_state == S_WAIT_R0 && RX_DATA_VALID)
                r_resp <= r_type == CMD_RF_RD ? OUT_WIDTH'(RX_P_DATA)
                                              : {r_resp[OUT_WIDTH-1:DATA_WIDTH], RX_P_DATA};
            if (r_state == S_WAIT_R1 && RX_DATA_VALID)
                r_resp[OUT_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
        end
    end
`ifdef CMD_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_wait;
    assign w_wait    = r_state == S_WAIT_R0 || r_state == S_WAIT_R1;
    assign w_timeout = w_wait && !RX_DATA_VALID && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign RESP_ERR  = r_state == S_DONE && r_err;
    // Held at zero outside the WAIT states, so it is already clear on entry to WAIT_R0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (!w_wait || RX_DATA_VALID) ? '0 : r_cnt + CW'(1);
            r_err <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign RESP_ERR  = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_frame_initiator.sv
// tb_cmd_frame_initiator: directed stimulus against a frame/response model with a per-cycle compare process
module tb_cmd_frame_initiator;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_READY;
    logic [1:0]  CMD_TYPE = '0;
    logic [3:0]  CMD_ADDR = '0, CMD_FUN = '0;
    logic [7:0]  CMD_WDATA = '0, CMD_OP_A = '0, CMD_OP_B = '0;
    logic [7:0]  TX_P_DATA, RX_P_DATA = '0;
    logic        TX_DATA_VALID, TX_FULL = 1'b0, RX_DATA_VALID = 1'b0;
    logic [15:0] RESP_DATA;
    logic        CMD_DONE, RESP_ERR;

    cmd_frame_initiator dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .CMD_OP_A(CMD_OP_A), .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN),
        .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_FULL(TX_FULL),
        .RX_P_DATA(RX_P_DATA), .RX_DATA_VALID(RX_DATA_VALID),
        .RESP_DATA(RESP_DATA), .CMD_DONE(CMD_DONE), .RESP_ERR(RESP_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // model state
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_log[$];
    logic [15:0] exp_resp = '0;
    logic [1:0]  cur_type = '0;
    int          rx_n = 0;
    bit          pending = 0, exp_err = 0;
    int          exp_done_cyc = -1;
    bit          stall_prev = 0;
    logic [7:0]  stall_byte = '0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // compare process: every cycle outside reset
    always @(negedge CLK) begin
        if (RST) begin
            stall_prev = 0;
        end else begin
            bit done_now;
            done_now = pending && cyc == exp_done_cyc;
            chk("cmd_ready", CMD_READY, !pending);
            chk("cmd_done", CMD_DONE, done_now);
            chk("resp_err", RESP_ERR, done_now && exp_err);
            if (done_now) chk("resp_data", RESP_DATA, exp_resp);
            if (stall_prev) chk("stall_stable", {TX_DATA_VALID, TX_P_DATA}, {1'b1, stall_byte});
            if (!TX_DATA_VALID) chk("tx_idle_zero", TX_P_DATA, 8'h00);
            if (TX_DATA_VALID && !TX_FULL) begin
                if (exp_q.size() == 0) begin
                    chk("tx_extra_byte", TX_P_DATA, 9'h100);
                end else begin
                    chk("tx_byte", TX_P_DATA, exp_q.pop_front());
                    tx_log.push_back(TX_P_DATA);
                    if (exp_q.size() == 0 && cur_type == 2'b00) exp_done_cyc = cyc + 1;
                end
            end
            if (TX_DATA_VALID && TX_FULL) stall_cnt++;
            stall_prev = TX_DATA_VALID && TX_FULL;
            stall_byte = TX_P_DATA;
            if (done_now) pending = 0;
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] wd,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        int n = 0;
        while (!CMD_READY && n < 100) begin tick(); n++; end
        chk("ready_before_cmd", CMD_READY, 1'b1);
        case (t)
            2'b00: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, ad}); exp_q.push_back(wd); end
            2'b01: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, ad}); end
            2'b10: begin exp_q.push_back(8'hCC); exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back({4'h0, f}); end
            default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); end
        endcase
        cur_type = t; rx_n = 0; exp_err = 0; exp_done_cyc = -1;
        tx_log.delete();
        CMD_TYPE = t; CMD_ADDR = ad; CMD_WDATA = wd; CMD_OP_A = a; CMD_OP_B = b; CMD_FUN = f;
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        pending = 1;
        chk("tx_valid_rise", TX_DATA_VALID, 1'b1);
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        chk("frame_complete", exp_q.size(), 0);
    endtask

    task automatic respond(input logic [7:0] v);
        bit last;
        if (cur_type == 2'b01) begin exp_resp = {8'h00, v}; last = 1; end
        else if (rx_n == 0) begin exp_resp[7:0] = v; last = 0; end
        else begin exp_resp[15:8] = v; last = 1; end
        rx_n++;
        RX_P_DATA = v; RX_DATA_VALID = 1'b1;
        if (last) exp_done_cyc = cyc + 1;
        tick();
        RX_DATA_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pending && n < 6000) begin tick(); n++; end
        chk("done_seen", pending, 1'b0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b0;
        chk("rst_ready", CMD_READY, 1'b1);
        chk("rst_tx_valid", TX_DATA_VALID, 1'b0);
        chk("rst_tx_data", TX_P_DATA, 8'h00);
        chk("rst_resp", RESP_DATA, 16'h0000);
        chk("rst_done", CMD_DONE, 1'b0);
        chk("rst_err", RESP_ERR, 1'b0);

        // RF write: AA 05 3C on consecutive cycles, done one cycle later, RESP unchanged
        send_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        wait_done();
        chk("wr_len", tx_log.size(), 3);
        if (tx_log.size() == 3) chk("wr_bytes", {tx_log[0], tx_log[1], tx_log[2]}, 24'hAA053C);
        chk("wr_resp_unchanged", RESP_DATA, 16'h0000);

        // RF read: BB 02, response 7E ten cycles later
        send_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        repeat (10) tick();
        respond(8'h7E);
        wait_done();
        if (tx_log.size() == 2) chk("rd_bytes", {tx_log[0], tx_log[1]}, 16'hBB02);
        else chk("rd_len", tx_log.size(), 2);
        chk("rd_resp", RESP_DATA, 16'h007E);

        // ALU with operands: CC 10 20 00, response 30 then 00
        send_cmd(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0);
        wait_tx_done();
        repeat (3) tick();
        respond(8'h30);
        repeat (2) tick();
        respond(8'h00);
        wait_done();
        if (tx_log.size() == 4) chk("alu_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hCC102000);
        else chk("alu_len", tx_log.size(), 4);
        chk("alu_resp", RESP_DATA, 16'h0030);

        // Backpressure on byte 1 of ALU-without-operands, FUN=2
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
        tick();
        stall_cnt = 0;
        TX_FULL = 1'b1;
        repeat (5) tick();
        TX_FULL = 1'b0;
        chk("bp_stall_cycles", stall_cnt, 5);
        wait_tx_done();
        respond(8'h34);
        respond(8'h12);
        wait_done();
        if (tx_log.size() == 2) chk("bp_bytes", {tx_log[0], tx_log[1]}, 16'hDD02);
        else chk("bp_len", tx_log.size(), 2);
        chk("bp_resp", RESP_DATA, 16'h1234);

        // Spurious RX during SEND (through the last transfer) and CMD_VALID while busy
        send_cmd(2'b10, 4'h0, 8'h00, 8'hA5, 8'h5A, 4'h7);
        RX_P_DATA = 8'hFF; RX_DATA_VALID = 1'b1;
        CMD_TYPE = 2'b00; CMD_ADDR = 4'hF; CMD_VALID = 1'b1;
        repeat (4) tick();
        RX_DATA_VALID = 1'b0; CMD_VALID = 1'b0;
        chk("spur_frame_sent", exp_q.size(), 0);
        repeat (2) tick();
        chk("spur_still_waiting", CMD_DONE, 1'b0);
        respond(8'h05);
        respond(8'h01);
        wait_done();
        chk("spur_len", tx_log.size(), 4);
        chk("spur_resp", RESP_DATA, 16'h0105);
        repeat (5) tick();
        chk("spur_no_second_frame", TX_DATA_VALID, 1'b0);

        // Reset mid-SEND
        TX_FULL = 1'b1;
        send_cmd(2'b00, 4'h9, 8'h77, 8'h00, 8'h00, 4'h0);
        repeat (2) tick();
        RST = 1'b1;
        exp_q.delete(); pending = 0; exp_done_cyc = -1;
        tick();
        RST = 1'b0;
        TX_FULL = 1'b0;
        chk("midrst_ready", CMD_READY, 1'b1);
        chk("midrst_tx_valid", TX_DATA_VALID, 1'b0);
        chk("midrst_tx_data", TX_P_DATA, 8'h00);
        chk("midrst_resp", RESP_DATA, 16'h0000);
        exp_resp = 16'h0000;
        repeat (3) tick();

        // Recovery: a fresh read after the aborted frame
        send_cmd(2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        respond(8'hC3);
        wait_done();
        chk("rec_resp", RESP_DATA, 16'h00C3);

`ifdef CMD_RESP_TIMEOUT_EN
        send_cmd(2'b01, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        exp_err = 1;
        exp_done_cyc = cyc + 4096;
        wait_done();
        chk("to_resp_unchanged", RESP_DATA, 16'h00C3);
        chk("to_ready", CMD_READY, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
